wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the five-stage RISC-V Lite pipeline, directly downstream of the memory stage.
- Holds the MEM/WB pipeline register and aligns and extends load data from the data SRAM.
- Selects the register-file write value, drives the register-file write port and forwarding taps, and detects ECALL/EBREAK to halt the core.

Parameters:
XLEN, 32, datapath width
NOP_INSTR, 32'h00000013, instruction word inserted on bubble/flush

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
EN  in  1  pipeline advance enable
START  in  1  core run enable; register updates only when EN & START
FLUSH  in  1  capture a bubble instead of the memory-stage outputs
WB_in_ALU_res  in  32  ALU result / effective address from the memory stage
WB_in_PC_add  in  32  PC+4 of the instruction in the memory stage
WB_in_instr  in  32  instruction word in the memory stage
WB_in_valid  in  1  memory-stage instruction is real (not a bubble)
WB_in_RegWrite  in  1  instruction writes rd
WB_in_MemtoReg  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU
WB_mem_data  in  32  SRAM dout; valid during the WB cycle of a load
WB_rd_addr  out  5  destination register
WB_rd_data  out  32  write-back value
WB_RegWrite  out  1  register-file write enable
WB_valid  out  1  a real instruction is retiring this cycle
WB_instr  out  32  retiring instruction (testbench trace)
WB_halted  out  1  sticky halt flag
WB_retire_cnt  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Clock/reset: one clock CLK; reset RST is asynchronous, active-high.
- Reset values: pipeline register all zero except instr = NOP_INSTR; valid = 0; state RUN; hold register and its flag = 0; retire counter = 0.
- Reset outputs: WB_rd_addr 0, WB_rd_data 0, WB_RegWrite 0, WB_valid 0, WB_instr NOP_INSTR, WB_halted 0, WB_retire_cnt 0.
- Pipeline register capture (adv = EN & START):
  - adv & FLUSH: capture bubble (valid 0, RegWrite 0, instr NOP_INSTR).
  - adv & ~FLUSH: capture all WB_in_* inputs.
  - ~adv: hold.
  - Latency: one cycle from memory stage to write-back, matching the one-cycle SRAM read.
- Load extraction (registered opcode == 7'b0000011; funct3 = instr[14:12]; off = ALU_res[1:0]):
  - LB: byte at lane off, sign-extended. LBU: same byte, zero-extended.
  - LH: halfword at lane off[1] (bits 15:0 or 31:16), sign-extended. LHU: same halfword, zero-extended.
  - LW: full word; off ignored.
  - Undefined funct3: full word.
  - Misaligned halfword (off[0]=1): use off[1] only; no trap.
- Load hold register:
  - On the first cycle with ~adv while a valid load occupies WB, latch the extracted load value and set the hold flag.
  - While the flag is set, load data comes from the hold register, not WB_mem_data.
  - Flag clears on the next adv.
- Result mux: WB_rd_data per WB_in_MemtoReg captured value; 11 behaves as 00.
- WB_rd_addr = instr[11:7]. WB_instr = registered instr.
- WB_RegWrite = valid & RegWrite & (rd != 0) & state==RUN & adv.
  - The write occurs once per retiring instruction. With the stage stalled, WB_RegWrite = 0.
- WB_valid = valid & adv & state==RUN.
- Halt FSM, states RUN and HALT:
  - RUN -> HALT on the clock edge where WB_valid = 1 and instr is 32'h00000073 (ECALL) or 32'h00100073 (EBREAK).
  - The ECALL/EBREAK itself counts as retired and never writes rd.
  - In HALT: WB_halted = 1, WB_RegWrite = 0, WB_valid = 0. The pipeline register keeps capturing.
  - HALT exits only via RST.
- Simultaneous FLUSH with a stalled load: FLUSH is ignored while ~adv; the hold flag persists.
- Reset mid-stall or mid-load: all state returns to reset values immediately and asynchronously.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: 32-bit counter increments by 1 each cycle WB_valid = 1; wraps 32'hFFFFFFFF -> 0; frozen in HALT; driven on WB_retire_cnt.
- Undefined: no counter flops; WB_retire_cnt tied to 0. The port exists in both builds.

Test Plan:
- Reset release, EN=START=1, WB_in_instr ADDI x5 (rd=5), RegWrite=1, MemtoReg=00, ALU_res 0x12 -> next cycle WB_RegWrite=1, WB_rd_addr=5, WB_rd_data=0x12.
- LB with ALU_res 0x1D (off=1), mem_data 0x0000_80FF -> WB_rd_data 0xFFFFFF80. LBU same inputs -> 0x00000080. LH off=2, mem_data 0x8001_0000 -> 0xFFFF8001.
- Valid load in WB, drop EN for 3 cycles while WB_mem_data changes to 0xDEADBEEF -> WB_RegWrite=0 while stalled. On EN re-assert, write carries the original loaded value exactly once.
- RegWrite=1 with rd=0 -> WB_RegWrite=0. MemtoReg=10 with PC_add 0x44 (JAL) -> WB_rd_data=0x44.
- ECALL retires -> WB_halted=1 next cycle. A following ADDI x6 gives WB_RegWrite=0 and WB_valid=0. RST pulse mid-HALT -> WB_halted=0.
- With WB_RETIRE_CNT_EN: 5 valid instructions plus 2 FLUSH bubbles -> WB_retire_cnt=5. Force the counter to 0xFFFFFFFF and retire 1 -> 0. Without the macro: WB_retire_cnt=0 throughout.

Source files
------------

// File: rtl/wb_stage_if.sv
// Memory-stage to write-back bundle: pipeline inputs plus SRAM read data.
interface wb_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] WB_in_ALU_res;
  logic [XLEN-1:0] WB_in_PC_add;
  logic [31:0]     WB_in_instr;
  logic            WB_in_valid;
  logic            WB_in_RegWrite;
  logic [1:0]      WB_in_MemtoReg;
  logic [XLEN-1:0] WB_mem_data;

  modport master (
    output WB_in_ALU_res,
    output WB_in_PC_add,
    output WB_in_instr,
    output WB_in_valid,
    output WB_in_RegWrite,
    output WB_in_MemtoReg,
    output WB_mem_data
  );

  modport slave (
    input WB_in_ALU_res,
    input WB_in_PC_add,
    input WB_in_instr,
    input WB_in_valid,
    input WB_in_RegWrite,
    input WB_in_MemtoReg,
    input WB_mem_data
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load align/extend, result mux, halt.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            START,
  input  logic            FLUSH,
  wb_stage_if.slave       mem,
  output logic [4:0]      WB_rd_addr,
  output logic [XLEN-1:0] WB_rd_data,
  output logic            WB_RegWrite,
  output logic            WB_valid,
  output logic [31:0]     WB_instr,
  output logic            WB_halted,
  output logic [31:0]     WB_retire_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] alu_q, pc_q;
  logic [31:0]     instr_q;
  logic            valid_q, rw_q;
  logic [1:0]      m2r_q;
  logic [XLEN-1:0] hold_q;
  logic            hold_flag_q;

  logic            adv, run, is_load, is_sys;
  logic [1:0]      off;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] ld_ext, load_val;

  assign adv     = EN & START;
  assign run     = (state_q == RUN);
  assign off     = alu_q[1:0];
  assign is_load = (instr_q[6:0] == 7'b0000011);
  assign is_sys  = (instr_q == 32'h0000_0073) ||
                   (instr_q == 32'h0010_0073);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_q   <= '0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 2'b00;
    end else if (adv) begin
      if (FLUSH) begin
        alu_q   <= '0;
        pc_q    <= '0;
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
        rw_q    <= 1'b0;
        m2r_q   <= 2'b00;
      end else begin
        alu_q   <= mem.WB_in_ALU_res;
        pc_q    <= mem.WB_in_PC_add;
        instr_q <= mem.WB_in_instr;
        valid_q <= mem.WB_in_valid;
        rw_q    <= mem.WB_in_RegWrite;
        m2r_q   <= mem.WB_in_MemtoReg;
      end
    end
  end

  always_comb begin
    byte_v = mem.WB_mem_data[7:0];
    case (off)
      2'd1:    byte_v = mem.WB_mem_data[15:8];
      2'd2:    byte_v = mem.WB_mem_data[23:16];
      2'd3:    byte_v = mem.WB_mem_data[31:24];
      default: byte_v = mem.WB_mem_data[7:0];
    endcase
    // Misaligned halfwords just pick the lane by off[1]; no trap.
    half_v = off[1] ? mem.WB_mem_data[31:16]
                    : mem.WB_mem_data[15:0];
    ld_ext = mem.WB_mem_data;
    if (is_load) begin
      case (instr_q[14:12])
        3'b000:  ld_ext = {{(XLEN-8){byte_v[7]}}, byte_v};
        3'b001:  ld_ext = {{(XLEN-16){half_v[15]}}, half_v};
        3'b100:  ld_ext = {{(XLEN-8){1'b0}}, byte_v};
        3'b101:  ld_ext = {{(XLEN-16){1'b0}}, half_v};
        default: ld_ext = mem.WB_mem_data;
      endcase
    end
  end

  // SRAM dout is only valid for one cycle; keep the value across a stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q      <= '0;
      hold_flag_q <= 1'b0;
    end else if (adv) begin
      hold_flag_q <= 1'b0;
    end else if (valid_q && is_load && !hold_flag_q) begin
      hold_q      <= ld_ext;
      hold_flag_q <= 1'b1;
    end
  end

  assign load_val = hold_flag_q ? hold_q : ld_ext;

  always_comb begin
    WB_rd_data = alu_q;
    case (m2r_q)
      2'b01:   WB_rd_data = load_val;
      2'b10:   WB_rd_data = pc_q;
      default: WB_rd_data = alu_q;
    endcase
  end

  assign WB_rd_addr  = instr_q[11:7];
  assign WB_instr    = instr_q;
  assign WB_valid    = valid_q & adv & run;
  assign WB_RegWrite = WB_valid & rw_q & ~is_sys &
                       (instr_q[11:7] != 5'd0);
  assign WB_halted   = (state_q == HALT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (WB_valid && is_sys) state_d = HALT;
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           retire_cnt_q <= '0;
    else if (WB_valid) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign WB_retire_cnt = retire_cnt_q;
`else
  assign WB_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard queue of expected WB outputs.
// Build with WB_RETIRE_CNT_EN defined to exercise the retire counter.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [4:0]  WB_rd_addr;
  logic [31:0] WB_rd_data;
  logic        WB_RegWrite;
  logic        WB_valid;
  logic [31:0] WB_instr;
  logic        WB_halted;
  logic [31:0] WB_retire_cnt;

  wb_stage_if bus ();

  wb_stage dut (
    .CLK           (CLK),
    .RST           (RST),
    .EN            (EN),
    .START         (START),
    .FLUSH         (FLUSH),
    .mem           (bus),
    .WB_rd_addr    (WB_rd_addr),
    .WB_rd_data    (WB_rd_data),
    .WB_RegWrite   (WB_RegWrite),
    .WB_valid      (WB_valid),
    .WB_instr      (WB_instr),
    .WB_halted     (WB_halted),
    .WB_retire_cnt (WB_retire_cnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // {valid, RegWrite, rd, data}
  logic [38:0] sb[$];
  logic [38:0] got, exp;

  function automatic logic [38:0] pk(input logic v, input logic rw,
                                     input logic [4:0] rd,
                                     input logic [31:0] d);
    return {v, rw, rd, d};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] md,
                       input logic v, input logic rw,
                       input logic [1:0] m2r, input logic fl);
    bus.WB_in_instr    = ins;
    bus.WB_in_ALU_res  = alu;
    bus.WB_in_PC_add   = pc;
    bus.WB_in_valid    = v;
    bus.WB_in_RegWrite = rw;
    bus.WB_in_MemtoReg = m2r;
    FLUSH = fl;
    EN    = 1'b1;
    START = 1'b1;
    @(posedge CLK);
    #1 bus.WB_mem_data = md;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    #1 RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    EN = 1'b0;
    START = 1'b0;
    #1 RST = 1'b1;
    @(negedge CLK);
    total++;
    if (WB_rd_addr !== 5'd0) begin
      bad++; $display("FAIL reset_rd_addr got=%h exp=0", WB_rd_addr);
    end
    total++;
    if (WB_rd_data !== 32'd0) begin
      bad++; $display("FAIL reset_rd_data got=%h exp=0", WB_rd_data);
    end
    total++;
    if (WB_RegWrite !== 1'b0) begin
      bad++; $display("FAIL reset_regwrite got=%b exp=0", WB_RegWrite);
    end
    total++;
    if (WB_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", WB_valid);
    end
    total++;
    if (WB_instr !== 32'h0000_0013) begin
      bad++; $display("FAIL reset_instr got=%h exp=00000013", WB_instr);
    end
    total++;
    if (WB_halted !== 1'b0) begin
      bad++; $display("FAIL reset_halted got=%b exp=0", WB_halted);
    end
    total++;
    if (WB_retire_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_cnt got=%h exp=0", WB_retire_cnt);
    end
    RST = 1'b0;
  endtask

  task automatic test_alu();
    sb.push_back(pk(1'b1, 1'b1, 5'd5, 32'h12));
    issue(32'h0120_0293, 32'h12, 32'h4, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0);
    got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL alu_addi got=%h exp=%h", got, exp);
    end
    total++;
    if (WB_instr !== 32'h0120_0293) begin
      bad++; $display("FAIL alu_instr got=%h exp=01200293", WB_instr);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3[9]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2,
                            3'd3, 3'd1, 3'd1, 3'd0};
    logic [31:0] al[9]  = '{32'h1D, 32'h1D, 32'h1E, 32'h1E, 32'h1F,
                            32'h20, 32'h23, 32'h21, 32'h23};
    logic [31:0] md[9]  = '{32'h0000_80FF, 32'h0000_80FF,
                            32'h8001_0000, 32'h8001_0000,
                            32'h89AB_CDEF, 32'hCAFE_F00D,
                            32'h8001_7FFE, 32'h0000_F123,
                            32'h7F00_0000};
    logic [31:0] ex[9]  = '{32'hFFFF_FF80, 32'h0000_0080,
                            32'hFFFF_8001, 32'h0000_8001,
                            32'h89AB_CDEF, 32'hCAFE_F00D,
                            32'hFFFF_8001, 32'hFFFF_F123,
                            32'h0000_007F};
    for (int i = 0; i < 9; i++) begin
      sb.push_back(pk(1'b1, 1'b1, 5'd10, ex[i]));
      issue({17'd0, f3[i], 5'd10, 7'b0000011}, al[i], 32'h0, md[i],
            1'b1, 1'b1, 2'b01, 1'b0);
      got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL load_%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_rd0_jal();
    sb.push_back(pk(1'b1, 1'b0, 5'd0, 32'h7));
    sb.push_back(pk(1'b1, 1'b1, 5'd1, 32'h44));
    sb.push_back(pk(1'b1, 1'b1, 5'd3, 32'h55));
    issue(32'h0070_0013, 32'h7, 32'h0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0);
    got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL rd0_nowrite got=%h exp=%h", got, exp);
    end
    issue(32'h0000_00EF, 32'h99, 32'h44, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0);
    got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL jal_pc4 got=%h exp=%h", got, exp);
    end
    issue(32'h0000_0193, 32'h55, 32'h77, 32'h0, 1'b1, 1'b1, 2'b11, 1'b0);
    got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL m2r11_alu got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_stall_load();
    bus.WB_in_instr    = {17'd0, 3'b000, 5'd12, 7'b0000011};
    bus.WB_in_ALU_res  = 32'h1D;
    bus.WB_in_PC_add   = 32'h0;
    bus.WB_in_valid    = 1'b1;
    bus.WB_in_RegWrite = 1'b1;
    bus.WB_in_MemtoReg = 2'b01;
    FLUSH = 1'b0;
    EN    = 1'b1;
    START = 1'b1;
    sb.push_back(pk(1'b1, 1'b1, 5'd12, 32'hFFFF_FF80));
    @(posedge CLK);
    #1;
    bus.WB_mem_data = 32'h0000_80FF;
    EN    = 1'b0;
    FLUSH = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      total++;
      if (WB_RegWrite !== 1'b0 || WB_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d got_rw=%b got_v=%b exp=0", c,
                 WB_RegWrite, WB_valid);
      end
      @(posedge CLK);
      #1 bus.WB_mem_data = 32'hDEAD_BEEF;
    end
    @(negedge CLK);
    FLUSH = 1'b0;
    bus.WB_in_valid    = 1'b0;
    bus.WB_in_RegWrite = 1'b0;
    EN = 1'b1;
    #1;
    got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL stall_release got=%h exp=%h", got, exp);
    end
    @(posedge CLK);
    @(negedge CLK);
    total++;
    if (WB_RegWrite !== 1'b0) begin
      bad++; $display("FAIL stall_once got=%b exp=0", WB_RegWrite);
    end
  endtask

  task automatic test_halt();
    sb.push_back(pk(1'b1, 1'b0, 5'd0, 32'h0));
    sb.push_back(pk(1'b0, 1'b0, 5'd6, 32'h1));
    sb.push_back(pk(1'b1, 1'b1, 5'd6, 32'h1));
    issue(32'h0000_0073, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
    got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
    exp = sb.pop_front();
    total++;
    if (got !== exp || WB_halted !== 1'b0) begin
      bad++;
      $display("FAIL ecall_retire got=%h h=%b exp=%h h=0", got,
               WB_halted, exp);
    end
    issue(32'h0010_0313, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0);
    total++;
    if (WB_halted !== 1'b1) begin
      bad++; $display("FAIL halt_set got=%b exp=1", WB_halted);
    end
    got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL halt_block got=%h exp=%h", got, exp);
    end
    #1 RST = 1'b1;
    #1;
    total++;
    if (WB_halted !== 1'b0 || WB_instr !== 32'h0000_0013) begin
      bad++;
      $display("FAIL halt_reset got_h=%b got_i=%h exp=0/00000013",
               WB_halted, WB_instr);
    end
    @(negedge CLK);
    RST = 1'b0;
    issue(32'h0010_0313, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0);
    got = {WB_valid, WB_RegWrite, WB_rd_addr, WB_rd_data};
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL post_reset_run got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_counter();
    logic [6:0] fl = 7'b0010100;
    logic [31:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 7; i++)
      issue(32'h0010_0393, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 2'b00, fl[i]);
    issue(32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    total++;
    if (WB_retire_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL cnt_five got=%h exp=%h", WB_retire_cnt, exp_cnt);
    end
`ifdef WB_RETIRE_CNT_EN
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    exp_cnt = 32'd0;
`endif
    issue(32'h0010_0393, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0);
    issue(32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
    total++;
    if (WB_retire_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL cnt_wrap got=%h exp=%h", WB_retire_cnt, exp_cnt);
    end
  endtask

  initial begin
    bus.WB_in_instr    = 32'h0000_0013;
    bus.WB_in_ALU_res  = '0;
    bus.WB_in_PC_add   = '0;
    bus.WB_in_valid    = 1'b0;
    bus.WB_in_RegWrite = 1'b0;
    bus.WB_in_MemtoReg = 2'b00;
    bus.WB_mem_data    = '0;
    test_reset();
    test_alu();
    test_loads();
    test_rd0_jal();
    test_stall_load();
    test_halt();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
